// File: rtl/counterdiv_prog.sv
// counterdiv_prog: runtime-programmable tick generator and clock divider
// with periodic-pulse, square-wave and one-shot modes; all outputs registered.
module counterdiv_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic [1:0]       mode_in,
    input  logic             start,
    output logic             tick,
    output logic             divclk,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        MODE_PULSE   = 2'b00,
        MODE_SQUARE  = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    logic [WIDTH-1:0] r_div;
    mode_e            r_mode;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_divclk;
    logic             r_busy;

    logic [WIDTH-1:0] w_div_nxt;
    mode_e            w_mode_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tick_nxt;
    logic             w_divclk_nxt;
    logic             w_busy_nxt;

    logic             w_last;
    logic             w_step;
    logic             w_wrap;
    logic             w_oneshot;

    assign w_oneshot = (r_mode == MODE_ONESHOT);
    assign w_last    = (r_count == r_div - WIDTH'(1));
    // An idle one-shot ignores en, so its counter stays parked at 0.
    assign w_step    = en && (!w_oneshot || r_busy);
    assign w_wrap    = w_step && w_last;

    always_comb begin
        w_div_nxt    = r_div;
        w_mode_nxt   = r_mode;
        w_count_nxt  = r_count;
        w_tick_nxt   = 1'b0;
        w_divclk_nxt = r_divclk;
        w_busy_nxt   = r_busy;
        if (load) begin
            w_div_nxt    = (div_in == '0) ? WIDTH'(1) : div_in;
            w_mode_nxt   = (mode_in == 2'b11) ? MODE_PULSE : mode_e'(mode_in);
            w_count_nxt  = '0;
            w_divclk_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (start && w_oneshot) begin
            // Restart beats a coincident wrap: no tick, stay busy.
            w_count_nxt = '0;
            w_busy_nxt  = 1'b1;
        end else if (w_wrap) begin
            w_count_nxt = '0;
            w_tick_nxt  = 1'b1;
            if (r_mode == MODE_SQUARE) w_divclk_nxt = ~r_divclk;
            if (w_oneshot)             w_busy_nxt   = 1'b0;
        end else if (w_step) begin
            w_count_nxt = r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= WIDTH'(DEFAULT_DIV);
            r_mode   <= MODE_PULSE;
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_divclk <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_mode   <= w_mode_nxt;
            r_count  <= w_count_nxt;
            r_tick   <= w_tick_nxt;
            r_divclk <= w_divclk_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign tick   = r_tick;
    assign divclk = r_divclk;
    assign busy   = r_busy;
    assign count  = r_count;

endmodule

// File: tb/tb_counterdiv_prog.sv
// Bench for counterdiv_prog: per-cycle vector table, expected outputs
// queued when each vector is driven and compared after the clock edge.
module tb_counterdiv_prog;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] div_in;
    logic [1:0]   mode_in;
    logic         start;
    logic         tick;
    logic         divclk;
    logic         busy;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    counterdiv_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .mode_in (mode_in),
        .start   (start),
        .tick    (tick),
        .divclk  (divclk),
        .busy    (busy),
        .count   (count)
    );

    typedef struct {
        bit       rst;
        bit       ld;
        int       dv;
        bit [1:0] md;
        bit       st;
        bit       en;
        int       c;
        bit       t;
        bit       d;
        bit       b;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input bit rst, input bit ld, input int dv,
                                input bit [1:0] md, input bit st,
                                input bit e, input int c, input bit t,
                                input bit d, input bit b);
        vec_t v;
        v.rst = rst; v.ld = ld; v.dv = dv; v.md = md; v.st = st;
        v.en = e; v.c = c; v.t = t; v.d = d; v.b = b;
        vecs.push_back(v);
    endfunction

    function automatic void en1(input int c, input bit t,
                                input bit d, input bit b);
        add(0, 0, 0, 2'd0, 0, 1, c, t, d, b);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d",
                     nm, idx, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        reset = 1'b1; en = 1'b0; load = 1'b0;
        div_in = '0; mode_in = 2'd0; start = 1'b0;

        // reset state
        add(1, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        // default div 4, mode 00; start ignored
        add(0, 0, 0, 2'd0, 1, 1, 1, 0, 0, 0);
        en1(2, 0, 0, 0); en1(3, 0, 0, 0); en1(0, 1, 0, 0);
        en1(1, 0, 0, 0); en1(2, 0, 0, 0); en1(3, 0, 0, 0);
        en1(0, 1, 0, 0); en1(1, 0, 0, 0);
        // div 3, square wave
        add(0, 1, 3, 2'd1, 0, 0, 0, 0, 0, 0);
        en1(1, 0, 0, 0); en1(2, 0, 0, 0); en1(0, 1, 1, 0);
        en1(1, 0, 1, 0); en1(2, 0, 1, 0); en1(0, 1, 0, 0);
        en1(1, 0, 0, 0); en1(2, 0, 0, 0); en1(0, 1, 1, 0);
        // div 0 saturates to 1; en on load cycle ignored
        add(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        en1(0, 1, 0, 0); en1(0, 1, 0, 0); en1(0, 1, 0, 0);
        add(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        // div 5, en toggling
        add(0, 1, 5, 2'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            en1(i, 0, 0, 0);
            add(0, 0, 0, 2'd0, 0, 0, i, 0, 0, 0);
        end
        en1(0, 1, 0, 0);
        add(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
        en1(1, 0, 0, 0);
        // reserved mode 11 behaves as 00
        add(0, 1, 2, 2'd3, 0, 0, 0, 0, 0, 0);
        en1(1, 0, 0, 0); en1(0, 1, 0, 0); en1(1, 0, 0, 0); en1(0, 1, 0, 0);
        // one-shot div 4: idle en ignored, then a shot with an en=0 hold
        add(0, 1, 4, 2'd2, 0, 0, 0, 0, 0, 0);
        en1(0, 0, 0, 0); en1(0, 0, 0, 0);
        add(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 1);
        en1(1, 0, 0, 1);
        add(0, 0, 0, 2'd0, 0, 0, 1, 0, 0, 1);
        en1(2, 0, 0, 1); en1(3, 0, 0, 1); en1(0, 1, 0, 0); en1(0, 0, 0, 0);
        // re-arm at count 2
        add(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 1);
        en1(1, 0, 0, 1); en1(2, 0, 0, 1);
        add(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 1);
        en1(1, 0, 0, 1); en1(2, 0, 0, 1); en1(3, 0, 0, 1); en1(0, 1, 0, 0);
        // start coincident with wrap: restart wins
        add(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 1);
        en1(1, 0, 0, 1); en1(2, 0, 0, 1); en1(3, 0, 0, 1);
        add(0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 1);
        en1(1, 0, 0, 1);
        // square div 4, then load div 6 mid-count with en
        add(0, 1, 4, 2'd1, 0, 0, 0, 0, 0, 0);
        en1(1, 0, 0, 0); en1(2, 0, 0, 0); en1(3, 0, 0, 0);
        en1(0, 1, 1, 0); en1(1, 0, 1, 0); en1(2, 0, 1, 0);
        add(0, 1, 6, 2'd1, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) en1(i, 0, 0, 0);
        en1(0, 1, 1, 0);
        for (int i = 1; i <= 5; i++) en1(i, 0, 1, 0);
        en1(0, 1, 0, 0);
        // reset together with load: defaults (div 4, mode 00) win
        add(1, 1, 2, 2'd1, 0, 1, 0, 0, 0, 0);
        en1(1, 0, 0, 0); en1(2, 0, 0, 0); en1(3, 0, 0, 0);
        en1(0, 1, 0, 0); en1(1, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset   = vecs[i].rst;
            load    = vecs[i].ld;
            div_in  = W'(vecs[i].dv);
            mode_in = vecs[i].md;
            start   = vecs[i].st;
            en      = vecs[i].en;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("count",  i, int'(count),  e.c);
            chk("tick",   i, int'(tick),   int'(e.t));
            chk("divclk", i, int'(divclk), int'(e.d));
            chk("busy",   i, int'(busy),   int'(e.b));
        end
        chk("scoreboard_left", 0, sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
